// File: rtl/rx_sm.sv
// rx_sm: receive-side controller and serial-to-parallel deserializer.
// Requests a byte with rx_ready, then samples tx_data while tx_valid is
// high (LSB first). Each full byte goes into a DEPTH-entry register file,
// and rx_finish is raised once the last entry has been written.
// Optional feature macro: RX_ERR_EN. It adds a sticky rx_err output that
// is set when a short burst is seen.
module rx_sm #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tx_valid,
  input  logic              tx_data,
  input  logic              rx_clear,
  output logic              rx_ready,
  output logic              rx_finish,
  output logic [ADDR_W-1:0] wr_addr,
  input  logic [ADDR_W-1:0] rd_addr,
`ifdef RX_ERR_EN
  output logic              rx_err,
`endif
  output logic [DATA_W-1:0] rd_data
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RECV,
    ST_STORE,
    ST_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic                rx_ready_q, rx_finish_q;
  logic                mem_we;
  logic [DATA_W-1:0]   mem_q [DEPTH];
`ifdef RX_ERR_EN
  logic                err_set;
  logic                rx_err_q, rx_err_d;
`endif

  // Next-state, datapath and write-enable decode.
  always_comb begin
    // NOTE: every variable gets a default before the case so that no path
    // leaves it unassigned, which would infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    wr_addr_d = wr_addr_q;
    mem_we    = 1'b0;
`ifdef RX_ERR_EN
    err_set   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (tx_valid) begin
          // The first valid cycle already carries bit 0.
          shift_d = {tx_data, shift_q[DATA_W-1:1]};
          cnt_d   = CNT_W'(1);
          state_d = ST_RECV;
        end
      end
      ST_RECV: begin
        if (tx_valid) begin
          // The transmitter's trailing valid cycle falls through once the
          // counter is full.
          if (cnt_q < CNT_W'(DATA_W)) begin
            shift_d = {tx_data, shift_q[DATA_W-1:1]};
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end else if (cnt_q == CNT_W'(DATA_W)) begin
          state_d = ST_STORE;
        end else begin
          // Short burst: drop the partial byte and ask again.
          cnt_d   = '0;
          state_d = ST_WAIT;
`ifdef RX_ERR_EN
          err_set = 1'b1;
`endif
        end
      end
      ST_STORE: begin
        mem_we    = 1'b1;
        cnt_d     = '0;
        wr_addr_d = wr_addr_q + ADDR_W'(1);
        state_d   = (wr_addr_q == ADDR_W'(DEPTH - 1)) ? ST_DONE : ST_WAIT;
      end
      ST_DONE: begin
        if (rx_clear) state_d = ST_WAIT;
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef RX_ERR_EN
  // Sticky error flag: a short burst sets it, rx_clear clears it.
  always_comb begin
    rx_err_d = rx_err_q;
    if (err_set)       rx_err_d = 1'b1;
    else if (rx_clear) rx_err_d = 1'b0;
  end
`endif

  // State, datapath and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      wr_addr_q   <= '0;
      rx_ready_q  <= 1'b0;
      rx_finish_q <= 1'b0;
`ifdef RX_ERR_EN
      rx_err_q    <= 1'b0;
`endif
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so every
      // register samples values from before the edge.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      wr_addr_q   <= wr_addr_d;
      // Decoded from next state so they are valid in the new state's first cycle.
      rx_ready_q  <= (state_d == ST_WAIT);
      rx_finish_q <= (state_d == ST_DONE);
`ifdef RX_ERR_EN
      rx_err_q    <= rx_err_d;
`endif
    end
  end

  // Register file write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the register file is reset explicitly because reads of
      // never-written entries must return zero. This is cheap only because
      // DEPTH is small.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[wr_addr_q] <= shift_q;
    end
  end

  assign rx_ready  = rx_ready_q;
  assign rx_finish = rx_finish_q;
  assign wr_addr   = wr_addr_q;
  assign rd_data   = mem_q[rd_addr];
`ifdef RX_ERR_EN
  assign rx_err    = rx_err_q;
`endif

endmodule

// File: tb/tb_rx_sm.sv
// Directed testbench for rx_sm. Inputs change on the falling clock edge,
// and outputs are checked on the falling edge before new inputs are driven.
module tb_rx_sm;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_valid = 1'b0;
  logic       tx_data = 1'b0;
  logic       rx_clear = 1'b0;
  logic       rx_ready;
  logic       rx_finish;
  logic [1:0] wr_addr;
  logic [1:0] rd_addr = 2'd0;
  logic [7:0] rd_data;
`ifdef RX_ERR_EN
  logic       rx_err;
`endif

  int n_vec = 0;
  int n_err = 0;

  rx_sm #(.DATA_W(8), .DEPTH(4), .ADDR_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .rx_clear  (rx_clear),
    .rx_ready  (rx_ready),
    .rx_finish (rx_finish),
    .wr_addr   (wr_addr),
    .rd_addr   (rd_addr),
`ifdef RX_ERR_EN
    .rx_err    (rx_err),
`endif
    .rd_data   (rd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic [1:0] exp_addr;
    logic       exp_ready;
    logic       exp_finish;
  } vec_t;

  vec_t tbl [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_mem(input logic [1:0] addr, input logic [7:0] exp, input string name);
    rd_addr = addr;
    #1;
    check(name, 32'(rd_data), 32'(exp));
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Drive nbits data bits LSB first, plus an optional trailing valid cycle,
  // then drop tx_valid. The task returns on the negedge where tx_valid falls.
  // rx_clear is pulsed during bit clear_at (use -1 for no pulse).
  task automatic burst(input logic [7:0] d, input int nbits, input bit trailing, input int clear_at);
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      tx_valid = 1'b1;
      tx_data  = d[i];
      rx_clear = (i == clear_at);
    end
    if (trailing) begin
      @(negedge clk);
      tx_data  = 1'b0;
      rx_clear = 1'b0;
    end
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data  = 1'b0;
    rx_clear = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 1'b0;
    rx_clear = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    tbl[0] = '{data: 8'h11, exp_addr: 2'd1, exp_ready: 1'b1, exp_finish: 1'b0};
    tbl[1] = '{data: 8'h22, exp_addr: 2'd2, exp_ready: 1'b1, exp_finish: 1'b0};
    tbl[2] = '{data: 8'h33, exp_addr: 2'd3, exp_ready: 1'b1, exp_finish: 1'b0};
    tbl[3] = '{data: 8'hC4, exp_addr: 2'd0, exp_ready: 1'b0, exp_finish: 1'b1};

    // Reset state, and the first cycle after release.
    do_reset();
    check("rst_ready",  32'(rx_ready),  32'd0);
    check("rst_finish", 32'(rx_finish), 32'd0);
    check("rst_waddr",  32'(wr_addr),   32'd0);
    for (int a = 0; a < 4; a++) check_mem(2'(a), 8'h00, "rst_mem");
    tick();
    check("ready_after_idle", 32'(rx_ready), 32'd1);

    // 0xA5, including the STORE-cycle read and handshake latency.
    burst(8'hA5, 8, 1'b1, -1);
    check("a5_ready_recv", 32'(rx_ready), 32'd0);
    tick();
    check("a5_ready_store", 32'(rx_ready), 32'd0);
    check("a5_waddr_store", 32'(wr_addr),  32'd0);
    check_mem(2'd0, 8'h00, "a5_old_in_store");
    tick();
    check("a5_ready_wait", 32'(rx_ready), 32'd1);
    check("a5_waddr",      32'(wr_addr),  32'd1);
    check_mem(2'd0, 8'hA5, "a5_mem0");

    // rx_clear pulsed in WAIT and in RECV has no effect.
    @(negedge clk); rx_clear = 1'b1;
    @(negedge clk); rx_clear = 1'b0;
    check("clr_wait_ready", 32'(rx_ready), 32'd1);
    burst(8'h5A, 8, 1'b1, 3);
    tick(); tick();
    check("clr_waddr", 32'(wr_addr), 32'd2);
    check_mem(2'd1, 8'h5A, "clr_mem1");

    // Short burst is discarded; the next full byte lands normally.
    burst(8'hFF, 5, 1'b0, -1);
    tick();
    check("short_ready", 32'(rx_ready), 32'd1);
    check("short_waddr", 32'(wr_addr),  32'd2);
    check_mem(2'd2, 8'h00, "short_mem2");
`ifdef RX_ERR_EN
    check("short_err", 32'(rx_err), 32'd1);
`endif
    burst(8'h3C, 8, 1'b1, -1);
    tick(); tick();
    check("3c_waddr", 32'(wr_addr), 32'd3);
    check_mem(2'd2, 8'h3C, "3c_mem2");

    // Asynchronous reset on the 4th bit of a burst.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tx_valid = 1'b1;
      tx_data  = 1'b1;
    end
    @(negedge clk);
    tx_data = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_waddr",  32'(wr_addr),   32'd0);
    check("mid_rst_ready",  32'(rx_ready),  32'd0);
    check("mid_rst_finish", 32'(rx_finish), 32'd0);
    check_mem(2'd0, 8'h00, "mid_rst_mem0");
    tx_valid = 1'b0;
    tx_data  = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    tick();
    check("mid_rst_rearm", 32'(rx_ready), 32'd1);
    burst(8'h7E, 8, 1'b1, -1);
    tick(); tick();
    check("7e_waddr", 32'(wr_addr), 32'd1);
    check_mem(2'd0, 8'h7E, "7e_mem0");

    // Four back-to-back bytes fill the file and reach DONE.
    do_reset();
    tick();
    for (int i = 0; i < 4; i++) begin
      burst(tbl[i].data, 8, 1'b1, -1);
      tick(); tick();
      check("tbl_waddr",  32'(wr_addr),   32'(tbl[i].exp_addr));
      check("tbl_ready",  32'(rx_ready),  32'(tbl[i].exp_ready));
      check("tbl_finish", 32'(rx_finish), 32'(tbl[i].exp_finish));
      check_mem(2'(i), tbl[i].data, "tbl_mem");
    end
    for (int i = 0; i < 4; i++) check_mem(2'(i), tbl[i].data, "full_mem");

    // A burst in DONE is ignored.
    burst(8'hFF, 8, 1'b1, -1);
    tick(); tick();
    check("done_finish", 32'(rx_finish), 32'd1);
    check("done_ready",  32'(rx_ready),  32'd0);
    check("done_waddr",  32'(wr_addr),   32'd0);
    check_mem(2'd0, 8'h11, "done_mem0");

    // rx_clear re-arms the block, and the next byte wraps to entry 0.
    @(negedge clk); rx_clear = 1'b1;
    @(negedge clk); rx_clear = 1'b0;
    check("clear_ready",  32'(rx_ready),  32'd1);
    check("clear_finish", 32'(rx_finish), 32'd0);
    burst(8'h99, 8, 1'b1, -1);
    tick(); tick();
    check("rearm_waddr", 32'(wr_addr), 32'd1);
    check_mem(2'd0, 8'h99, "rearm_mem0");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
